stream_demux3: RTL and testbench

- One-input, three-output registered demultiplexer; the write-side counterpart of the team's 3:1 alpha/beta/gamma select mux.
- Routes a single 8-bit valid/ready input stream to one of three output channels (alpha, beta, gamma) according to a 2-bit select, gated by chip select.
- Each output has a one-entry registered buffer with valid/ready backpressure.
- Select code 3 discards the beat and counts it. Sits between a single producer and three independent consumers.

---
 rtl/stream_demux3_pkg.sv | 37 +++
 rtl/stream_demux3_if.sv | 64 ++++++
 rtl/demux_slot.sv | 45 ++++
 rtl/stream_demux3.sv | 83 ++++++++
 tb/tb_stream_demux3.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/stream_demux3_pkg.sv
//======================================================================
// Module      : stream_demux3_pkg
// Description : Shared types and defaults for the 1:3 stream demux.
// Revision    : 1.0 - initial release
//======================================================================
`default_nettype none

package stream_demux3_pkg;

  // Destination encoding carried on in_sel
  typedef enum logic [1:0] {
    DEST_ALPHA = 2'd0,
    DEST_BETA  = 2'd1,
    DEST_GAMMA = 2'd2,
    DEST_DROP  = 2'd3
  } dest_e;

  localparam int c_DATA_W_DEFAULT = 8;
  localparam int c_CNT_W_DEFAULT  = 8;

  // One-hot view of a destination: bit 3 is the discard path
  function automatic logic [3:0] dest_onehot(input dest_e d);
    logic [3:0] v;
    v = 4'b0000;
    case (d)
      DEST_ALPHA: v = 4'b0001;
      DEST_BETA:  v = 4'b0010;
      DEST_GAMMA: v = 4'b0100;
      DEST_DROP:  v = 4'b1000;
      default:    v = 4'b0000;
    endcase
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_demux3_if.sv
//======================================================================
// Module      : stream_demux3_if
// Description : Producer input stream plus three consumer channels and
//               the drop counter of the 1:3 stream demux.
// Revision    : 1.0 - initial release
//======================================================================
`default_nettype none

interface stream_demux3_if
  import stream_demux3_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEFAULT,
  parameter int CNT_W  = c_CNT_W_DEFAULT
);

  logic              cs;
  logic [1:0]        in_sel;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  logic              alpha_valid;
  logic [DATA_W-1:0] alpha_data;
  logic              alpha_ready;

  logic              beta_valid;
  logic [DATA_W-1:0] beta_data;
  logic              beta_ready;

  logic              gamma_valid;
  logic [DATA_W-1:0] gamma_data;
  logic              gamma_ready;

  logic [CNT_W-1:0]  drop_count;

  // Environment side: drives the producer stream and consumer readys
  modport master (
    output cs, in_sel, in_valid, in_data,
    input  in_ready,
    input  alpha_valid, alpha_data,
    output alpha_ready,
    input  beta_valid, beta_data,
    output beta_ready,
    input  gamma_valid, gamma_data,
    output gamma_ready,
    input  drop_count
  );

  // Demux side
  modport slave (
    input  cs, in_sel, in_valid, in_data,
    output in_ready,
    output alpha_valid, alpha_data,
    input  alpha_ready,
    output beta_valid, beta_data,
    input  beta_ready,
    output gamma_valid, gamma_data,
    input  gamma_ready,
    output drop_count
  );

endinterface

`default_nettype wire

// File: rtl/demux_slot.sv
//======================================================================
// Module      : demux_slot
// Description : One-entry valid/ready output register. The slot counts
//               as free while empty or while being drained, so a load
//               and a drain can happen in the same cycle.
// Revision    : 1.0 - initial release
//======================================================================
`default_nettype none

module demux_slot #(
  parameter int DATA_W = 8
) (
  input  wire logic              clk,
  input  wire logic              nreset,
  input  wire logic              load,
  input  wire logic [DATA_W-1:0] load_data,
  input  wire logic              ready,
  output logic                   valid,
  output logic [DATA_W-1:0]      data,
  output logic                   free
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Load is only raised while free, so data never changes under a stall
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= load_data;
    end else if (ready) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign data  = r_data;
  assign free  = !r_valid || ready;

endmodule

`default_nettype wire

// File: rtl/stream_demux3.sv
//======================================================================
// Module      : stream_demux3
// Description : Routes one valid/ready byte stream to alpha/beta/gamma
//               registered output slots by in_sel; in_sel=3 accepts
//               and discards the beat, counting it saturating.
// Revision    : 1.0 - initial release
//======================================================================
`default_nettype none

module stream_demux3
  import stream_demux3_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEFAULT,
  parameter int CNT_W  = c_CNT_W_DEFAULT
) (
  input wire logic         clk,
  input wire logic         nreset,
  stream_demux3_if.slave   bus
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  dest_e             w_dest;
  logic [3:0]        w_dest_oh;
  logic [3:0]        w_avail;
  logic              w_in_ready;
  logic              w_xfer;
  logic [2:0]        w_load;
  logic [2:0]        w_ready;
  logic [2:0]        w_valid;
  logic [2:0]        w_free;
  logic [DATA_W-1:0] w_data [3];
  logic [CNT_W-1:0]  r_drop_count;

  assign w_dest    = dest_e'(bus.in_sel);
  assign w_dest_oh = dest_onehot(w_dest);

  // The discard path is always available; channels only when free
  assign w_avail    = {1'b1, w_free};
  assign w_in_ready = bus.cs && w_avail[bus.in_sel];
  assign w_xfer     = bus.in_valid && w_in_ready;
  assign w_load     = w_xfer ? w_dest_oh[2:0] : 3'b000;

  assign w_ready = {bus.gamma_ready, bus.beta_ready, bus.alpha_ready};

  generate
    for (genvar k = 0; k < 3; k++) begin : g_slot
      demux_slot #(
        .DATA_W (DATA_W)
      ) u_slot (
        .clk       (clk),
        .nreset    (nreset),
        .load      (w_load[k]),
        .load_data (bus.in_data),
        .ready     (w_ready[k]),
        .valid     (w_valid[k]),
        .data      (w_data[k]),
        .free      (w_free[k])
      );
    end
  endgenerate

  // Count discarded beats, sticking at all-ones
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_drop_count <= '0;
    end else if (w_xfer && (w_dest == DEST_DROP) && (r_drop_count != c_CNT_MAX)) begin
      r_drop_count <= r_drop_count + 1'b1;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.alpha_valid = w_valid[0];
  assign bus.alpha_data  = w_data[0];
  assign bus.beta_valid  = w_valid[1];
  assign bus.beta_data   = w_data[1];
  assign bus.gamma_valid = w_valid[2];
  assign bus.gamma_data  = w_data[2];
  assign bus.drop_count  = r_drop_count;

endmodule

`default_nettype wire

// File: tb/tb_stream_demux3.sv
//======================================================================
// Module      : tb_stream_demux3
// Description : Directed self-checking bench for stream_demux3 with a
//               2-bit drop counter so saturation is reached quickly.
// Revision    : 1.0 - initial release
//======================================================================
`default_nettype none

module tb_stream_demux3;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;

  logic clk;
  logic nreset;
  int   n_checks;
  int   n_errors;

  stream_demux3_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  stream_demux3 #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    nreset = 1'b0;
    bus.cs = 1'b0;
    bus.in_sel = 2'd0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.alpha_ready = 1'b0;
    bus.beta_ready = 1'b0;
    bus.gamma_ready = 1'b0;

    // Reset
    tick();
    tick();
    check("rst_alpha_valid", 32'(bus.alpha_valid), 32'd0);
    check("rst_beta_valid", 32'(bus.beta_valid), 32'd0);
    check("rst_gamma_valid", 32'(bus.gamma_valid), 32'd0);
    check("rst_alpha_data", 32'(bus.alpha_data), 32'h00);
    check("rst_drop_count", 32'(bus.drop_count), 32'd0);
    nreset = 1'b1;
    tick();
    check("rst_in_ready_cs0", 32'(bus.in_ready), 32'd0);
    check("rst_gamma_data", 32'(bus.gamma_data), 32'h00);

    // Routing to beta
    bus.alpha_ready = 1'b1;
    bus.beta_ready = 1'b1;
    bus.gamma_ready = 1'b1;
    bus.cs = 1'b1;
    bus.in_sel = 2'd1;
    bus.in_data = 8'hA5;
    bus.in_valid = 1'b1;
    #1;
    check("route_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("route_beta_valid", 32'(bus.beta_valid), 32'd1);
    check("route_beta_data", 32'(bus.beta_data), 32'hA5);
    check("route_alpha_valid", 32'(bus.alpha_valid), 32'd0);
    check("route_gamma_valid", 32'(bus.gamma_valid), 32'd0);
    tick();
    check("route_beta_drained", 32'(bus.beta_valid), 32'd0);
    check("route_beta_data_hold", 32'(bus.beta_data), 32'hA5);

    // Backpressure on alpha
    bus.alpha_ready = 1'b0;
    bus.in_sel = 2'd0;
    bus.in_data = 8'h11;
    bus.in_valid = 1'b1;
    #1;
    check("bp_first_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("bp_alpha_valid", 32'(bus.alpha_valid), 32'd1);
    check("bp_alpha_data_11", 32'(bus.alpha_data), 32'h11);
    bus.in_data = 8'h22;
    #1;
    check("bp_stall_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("bp_alpha_data_held", 32'(bus.alpha_data), 32'h11);
    check("bp_alpha_valid_held", 32'(bus.alpha_valid), 32'd1);
    bus.alpha_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_alpha_valid_22", 32'(bus.alpha_valid), 32'd1);
    check("bp_alpha_data_22", 32'(bus.alpha_data), 32'h22);
    tick();
    check("bp_alpha_drained", 32'(bus.alpha_valid), 32'd0);

    // Back-to-back throughput to gamma
    bus.in_sel = 2'd2;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = 8'(i);
      bus.in_valid = 1'b1;
      #1;
      check("tp_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      check("tp_gamma_valid", 32'(bus.gamma_valid), 32'd1);
      check("tp_gamma_data", 32'(bus.gamma_data), 32'(i));
    end

    // Discard path and counter saturation
    bus.in_sel = 2'd3;
    bus.in_data = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      #1;
      check("drop_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      check("drop_count", 32'(bus.drop_count), (i < 3) ? 32'(i + 1) : 32'd3);
      check("drop_no_valid", 32'({bus.alpha_valid, bus.beta_valid, bus.gamma_valid}), 32'd0);
    end
    bus.in_valid = 1'b0;

    // Chip-select gate
    bus.cs = 1'b0;
    bus.in_sel = 2'd2;
    bus.in_data = 8'h77;
    bus.in_valid = 1'b1;
    #1;
    check("cs0_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("cs0_gamma_valid", 32'(bus.gamma_valid), 32'd0);
    bus.in_valid = 1'b0;

    // Reset mid-stream clears a stalled beat without waiting for a clock
    bus.cs = 1'b1;
    bus.alpha_ready = 1'b0;
    bus.in_sel = 2'd0;
    bus.in_data = 8'h5A;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("mid_alpha_valid", 32'(bus.alpha_valid), 32'd1);
    check("mid_alpha_data", 32'(bus.alpha_data), 32'h5A);
    #2;
    nreset = 1'b0;
    #1;
    check("mid_rst_alpha_valid", 32'(bus.alpha_valid), 32'd0);
    check("mid_rst_alpha_data", 32'(bus.alpha_data), 32'h00);
    check("mid_rst_drop_count", 32'(bus.drop_count), 32'd0);
    tick();
    nreset = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
